// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared types and constants for the AXI4-Lite master: one-hot
//               sequencer state encoding and AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  // One-hot encoding keeps state decode to a single bit per state.
  typedef enum logic [5:0] {
    ST_IDLE       = 6'b000001,
    ST_WRITE_REQ  = 6'b000010,
    ST_WRITE_RESP = 6'b000100,
    ST_READ_REQ   = 6'b001000,
    ST_READ_RESP  = 6'b010000,
    ST_RESPOND    = 6'b100000
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_if.sv
`default_nettype none
// ============================================================================
// Module      : AXI_BUS
// Description : AXI4-Lite bus bundle (AW, W, B, AR, R) with Master and Slave
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface AXI_BUS #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master
// Description : Single-outstanding AXI4-Lite initiator. Converts valid/ready
//               word requests into AXI transactions and hands back the slave
//               response code untouched. All outputs are registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   req_valid,
  output logic                  req_ready,
  input  wire                   req_write,
  input  wire  [ADDR_WIDTH-1:0] req_addr,
  input  wire  [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  wire                   rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  AXI_BUS.Master                amba_master
);

  state_e                state_q;
  logic                  req_ready_q;
  logic                  aw_valid_q;
  logic                  w_valid_q;
  logic                  b_ready_q;
  logic                  ar_valid_q;
  logic                  r_ready_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_ar_fire;
  logic w_r_fire;

  assign w_aw_fire = aw_valid_q && amba_master.aw_ready;
  assign w_w_fire  = w_valid_q  && amba_master.w_ready;
  assign w_b_fire  = b_ready_q  && amba_master.b_valid;
  assign w_ar_fire = ar_valid_q && amba_master.ar_ready;
  assign w_r_fire  = r_ready_q  && amba_master.r_valid;

  // Transaction sequencer: one request in flight, AW and W issued together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            rsp_write_q <= req_write;
            if (req_write) begin
              aw_addr_q  <= req_addr;
              w_data_q   <= req_wdata;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
              state_q    <= ST_WRITE_REQ;
            end else begin
              ar_addr_q  <= req_addr;
              ar_valid_q <= 1'b1;
              state_q    <= ST_READ_REQ;
            end
          end
        end
        ST_WRITE_REQ: begin
          // Each channel retires on its own handshake, in any order.
          if (w_aw_fire) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_w_fire) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if ((aw_done_q || w_aw_fire) && (w_done_q || w_w_fire)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_ready_q <= 1'b1;
            state_q   <= ST_WRITE_RESP;
          end
        end
        ST_WRITE_RESP: begin
          if (w_b_fire) begin
            b_ready_q   <= 1'b0;
            rsp_resp_q  <= amba_master.b_resp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end
        end
        ST_READ_REQ: begin
          if (w_ar_fire) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_READ_RESP;
          end
        end
        ST_READ_RESP: begin
          if (w_r_fire) begin
            r_ready_q   <= 1'b0;
            rsp_rdata_q <= amba_master.r_data;
            rsp_resp_q  <= amba_master.r_resp;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encodings fall back to a quiet idle.
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          aw_valid_q  <= 1'b0;
          w_valid_q   <= 1'b0;
          b_ready_q   <= 1'b0;
          ar_valid_q  <= 1'b0;
          r_ready_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready            = req_ready_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_write            = rsp_write_q;
  assign rsp_rdata            = rsp_rdata_q;
  assign rsp_resp             = rsp_resp_q;
  assign amba_master.aw_addr  = aw_addr_q;
  assign amba_master.aw_valid = aw_valid_q;
  assign amba_master.w_data   = w_data_q;
  assign amba_master.w_valid  = w_valid_q;
  assign amba_master.b_ready  = b_ready_q;
  assign amba_master.ar_addr  = ar_addr_q;
  assign amba_master.ar_valid = ar_valid_q;
  assign amba_master.r_ready  = r_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_master
// Description : Self-checking bench for axi4_lite_master with a behavioural
//               AXI4-Lite memory slave and a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  AXI_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .amba_master (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_write, rsp_resp, bus.aw_valid,
                           bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 64'd0);
    check({tag, "_data"}, {rsp_rdata, bus.w_data}, 64'd0);
    check({tag, "_addr"}, {bus.aw_addr, bus.ar_addr}, 64'd0);
  endtask

  // Slave behaviour knobs and the two memories (slave storage, reference model).
  int            cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
  logic [1:0]    cfg_b_resp, cfg_r_resp;
  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            w_cyc;

  // Memory slave: readies after a programmable number of valid cycles, B/R
  // raised a programmable number of cycles after the request completes.
  // Everything is driven at the falling edge; handshakes are reconstructed
  // from what was presented at the previous rising edge.
  logic          aw_got, w_got, b_pend, r_pend;
  int            aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic [AW-1:0] s_addr, r_addr, p_aw_a, p_ar_a;
  logic [DW-1:0] s_data, p_w_d;
  logic          p_aw_v, p_w_v, p_ar_v, p_b_r, p_r_r;

  initial begin
    logic hs_aw, hs_w, hs_ar, hs_b, hs_r;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0;    bus.r_resp = 2'b00;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
    p_aw_v = 0; p_w_v = 0; p_ar_v = 0; p_b_r = 0; p_r_r = 0;
    s_addr = '0; r_addr = '0; p_aw_a = '0; p_ar_a = '0; s_data = '0; p_w_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        p_aw_v = 0; p_w_v = 0; p_ar_v = 0; p_b_r = 0; p_r_r = 0;
        continue;
      end
      hs_aw = p_aw_v && bus.aw_ready;
      hs_w  = p_w_v  && bus.w_ready;
      hs_ar = p_ar_v && bus.ar_ready;
      hs_b  = bus.b_valid && p_b_r;
      hs_r  = bus.r_valid && p_r_r;
      // A valid never drops or changes payload before its handshake.
      if (p_aw_v && !hs_aw) begin
        check("aw_hold", bus.aw_valid, 1);
        check("aw_addr_stable", bus.aw_addr, p_aw_a);
      end
      if (p_w_v && !hs_w) begin
        check("w_hold", bus.w_valid, 1);
        check("w_data_stable", bus.w_data, p_w_d);
      end
      if (p_ar_v && !hs_ar) begin
        check("ar_hold", bus.ar_valid, 1);
        check("ar_addr_stable", bus.ar_addr, p_ar_a);
      end
      if (hs_aw) begin
        check("aw_drop", bus.aw_valid, 0);
        check("aw_addr", p_aw_a, cur_addr);
        aw_got = 1; s_addr = p_aw_a;
      end
      if (hs_w) begin
        check("w_drop", bus.w_valid, 0);
        check("w_data", p_w_d, cur_wdata);
        w_got = 1; s_data = p_w_d;
      end
      if (hs_ar) begin
        check("ar_drop", bus.ar_valid, 0);
        check("ar_addr", p_ar_a, cur_addr);
        r_pend = 1; r_wait = cfg_r_dly; r_addr = p_ar_a;
      end
      if (hs_b) bus.b_valid = 1'b0;
      if (hs_r) bus.r_valid = 1'b0;
      if (aw_got && w_got) begin
        smem[s_addr] = s_data;
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = cfg_b_dly;
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          bus.b_valid = 1'b1; bus.b_resp = cfg_b_resp; b_pend = 0;
        end else b_wait--;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          bus.r_valid = 1'b1; bus.r_data = smem[r_addr]; bus.r_resp = cfg_r_resp; r_pend = 0;
        end else r_wait--;
      end
      if (bus.aw_valid) begin bus.aw_ready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin bus.aw_ready = 1'b0; aw_cnt = 0; end
      if (bus.w_valid) begin bus.w_ready = (w_cnt >= cfg_w_dly); w_cnt++; w_cyc++; end
      else begin bus.w_ready = 1'b0; w_cnt = 0; end
      if (bus.ar_valid) begin bus.ar_ready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
      else begin bus.ar_ready = 1'b0; ar_cnt = 0; end
      p_aw_v = bus.aw_valid; p_aw_a = bus.aw_addr;
      p_w_v  = bus.w_valid;  p_w_d  = bus.w_data;
      p_ar_v = bus.ar_valid; p_ar_a = bus.ar_addr;
      p_b_r  = bus.b_ready;  p_r_r  = bus.r_ready;
    end
  end

  // One command/response exchange; called and returns at a falling edge.
  // lat = rising edges from the acceptance edge to the edge raising rsp_valid.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold, output int lat);
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    int            n;
    check("single_outstanding", {bus.aw_valid, bus.w_valid, bus.ar_valid, rsp_valid}, 0);
    cur_addr = a; cur_wdata = d;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", n < 50, 1);
    @(posedge clk);
    w_cyc = 0;
    if (wr) begin
      mmem[a] = d; exp_rdata = '0; exp_resp = cfg_b_resp;
    end else begin
      exp_rdata = mmem[a]; exp_resp = cfg_r_resp;
    end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    check("req_ready_busy", req_ready, 0);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk); lat++;
      if (rsp_valid !== 1'b1) check("req_ready_busy", req_ready, 0);
    end
    check("rsp_timeout", lat < 60, 1);
    check("rsp_write", rsp_write, wr);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp", rsp_resp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_write, rsp_resp}, {1'b1, wr, exp_resp});
      check("rsp_hold_rdata", rsp_rdata, exp_rdata);
      check("req_ready_stall", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < (1 << AW); i++) begin smem[i] = '0; mmem[i] = '0; end
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_b_dly = 1; cfg_r_dly = 1;
    cfg_b_resp = RESP_OKAY; cfg_r_resp = RESP_OKAY;
    cur_addr = '0; cur_wdata = '0; w_cyc = 0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    #1 check("req_ready_release", req_ready, 0);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);

    // Concurrent AW/W, decode-error response.
    cfg_b_resp = RESP_DECERR;
    run_txn(1'b1, 10'h004, 32'hDEADBEEF, 0, lat);
    check("lat_write", lat, 3);

    // Read back.
    cfg_r_resp = RESP_OKAY;
    run_txn(1'b0, 10'h004, 32'h0, 0, lat);
    check("lat_read", lat, 3);

    // AW accepted first, W two cycles later.
    cfg_b_resp = RESP_OKAY; cfg_w_dly = 2;
    run_txn(1'b1, 10'h010, 32'h12345678, 0, lat);
    check("lat_aw_then_w", lat, 5);
    check("w_valid_cycles", w_cyc, 3);
    cfg_w_dly = 0;

    // Slow AR and stalled response consumer.
    cfg_ar_dly = 5; cfg_r_resp = RESP_EXOKAY;
    run_txn(1'b0, 10'h010, 32'h0, 4, lat);
    check("lat_ar_stall", lat, 8);
    cfg_ar_dly = 0; cfg_r_resp = RESP_OKAY;

    // Reset while waiting for B; the slave already stored the write.
    cfg_b_dly = 6;
    cur_addr = 10'h3FF; cur_wdata = 32'hA5A55A5A;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3FF; req_wdata = 32'hA5A55A5A;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (bus.b_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("reach_write_resp", n < 50, 1);
    mmem[10'h3FF] = 32'hA5A55A5A;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    cfg_b_dly = 1;
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);
    run_txn(1'b0, 10'h3FF, 32'h0, 0, lat);
    check("lat_after_reset", lat, 3);

    // Back-to-back random traffic with random slave stalls.
    for (int t = 0; t < 16; t++) begin
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
      cfg_ar_dly = $urandom_range(0, 3); cfg_b_dly = $urandom_range(0, 3);
      cfg_r_dly  = $urandom_range(0, 3);
      cfg_b_resp = 2'($urandom_range(0, 3)); cfg_r_resp = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), $urandom,
              $urandom_range(0, 2), lat);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
